// File: rtl/fetch_exc.sv
// Fetch-stage PC unit: sequential fetch, branches, exception vectoring with an
// exception link register, ERET, stall, and trapping of misaligned branch targets.
module fetch_exc #(
    parameter int unsigned  N          = 64,
    parameter logic [N-1:0] RESET_PC   = '0,
    parameter logic [N-1:0] EXC_VECTOR = 'hD8,
    parameter int unsigned  INC        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCSrc_F,
    input  logic [N-1:0] PCBranch_F,
    input  logic         Stall_F,
    input  logic         Exc_F,
    input  logic [N-1:0] ExcPC_F,
    input  logic         ERet_F,
    output logic [N-1:0] imem_addr_F,
    output logic [N-1:0] ELR_F,
    output logic         InExc_F,
    output logic         Misalign_F
);

    localparam int unsigned LG = $clog2(INC);

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] elr_q, elr_d;
    logic         mis_q, mis_d;
    logic         mis;

    // Branch target not a multiple of INC: low log2(INC) bits must be zero.
    assign mis = PCSrc_F && (PCBranch_F[LG-1:0] != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NORMAL;
            pc_q    <= RESET_PC;
            elr_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            elr_q   <= elr_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q + N'(INC);
        elr_d   = elr_q;
        mis_d   = 1'b0;
        if (Exc_F) begin
            // A nested exception keeps the first return address.
            if (state_q == NORMAL) elr_d = ExcPC_F;
            pc_d    = EXC_VECTOR;
            state_d = HANDLER;
        end else if (mis) begin
            if (state_q == NORMAL) elr_d = PCBranch_F;
            pc_d    = EXC_VECTOR;
            mis_d   = 1'b1;
            state_d = HANDLER;
        end else if (ERet_F && (state_q == HANDLER)) begin
            pc_d    = elr_q;
            state_d = NORMAL;
        end else if (PCSrc_F) begin
            pc_d = PCBranch_F;
        end else if (Stall_F) begin
            pc_d = pc_q;
        end
    end

    assign imem_addr_F = pc_q;
    assign ELR_F       = elr_q;
    assign InExc_F     = (state_q == HANDLER);
    assign Misalign_F  = mis_q;

endmodule

// File: tb/tb_fetch_exc.sv
// Scoreboard bench for fetch_exc: stimulus pushes model expectations, a monitor
// pops and compares them 1ns after each rising edge.
module tb_fetch_exc;

    localparam int unsigned N   = 64;
    localparam logic [63:0] EXC = 64'hD8;
    localparam logic [63:0] INC = 64'd4;

    logic        clk, reset;
    logic        PCSrc_F, Stall_F, Exc_F, ERet_F;
    logic [63:0] PCBranch_F, ExcPC_F;
    logic [63:0] imem_addr_F, ELR_F;
    logic        InExc_F, Misalign_F;

    fetch_exc #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F), .Stall_F(Stall_F),
        .Exc_F(Exc_F), .ExcPC_F(ExcPC_F), .ERet_F(ERet_F),
        .imem_addr_F(imem_addr_F), .ELR_F(ELR_F),
        .InExc_F(InExc_F), .Misalign_F(Misalign_F)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] elr;
        logic        inexc;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, passed = 0;

    // reference architectural state
    logic [63:0] m_pc, m_elr;
    logic        m_in;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = '0; m_elr = '0; m_in = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the architectural
    // state the spec's priority rules give after the next rising edge.
    task automatic step(input logic pcsrc, input logic [63:0] br, input logic stall,
                        input logic exc, input logic [63:0] epc, input logic eret);
        exp_t e;
        logic misal;
        @(negedge clk);
        PCSrc_F = pcsrc; PCBranch_F = br; Stall_F = stall;
        Exc_F = exc; ExcPC_F = epc; ERet_F = eret;
        misal = pcsrc && ((br % INC) != 0);
        e.mis = 1'b0;
        if (exc) begin
            if (!m_in) m_elr = epc;
            m_pc = EXC; m_in = 1'b1;
        end else if (misal) begin
            if (!m_in) m_elr = br;
            m_pc = EXC; m_in = 1'b1; e.mis = 1'b1;
        end else if (eret && m_in) begin
            m_pc = m_elr; m_in = 1'b0;
        end else if (pcsrc) begin
            m_pc = br;
        end else if (!stall) begin
            m_pc = m_pc + INC;
        end
        e.pc = m_pc; e.elr = m_elr; e.inexc = m_in;
        sb.push_back(e);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0, 0);
    endtask

    task automatic branch(input logic [63:0] t);
        step(1, t, 0, 0, '0, 0);
    endtask

    // Spot-check against a literal from the spec just after the edge that follows a step.
    task automatic now(input string name, input logic [63:0] act_sel, input logic [63:0] exp);
        chk(name, act_sel, exp);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("addr",  imem_addr_F, e.pc);
                chk("elr",   ELR_F,       e.elr);
                chk("inexc", {63'b0, InExc_F},    {63'b0, e.inexc});
                chk("mis",   {63'b0, Misalign_F}, {63'b0, e.mis});
            end
        end
    end

    initial begin
        reset = 1'b1;
        PCSrc_F = 0; PCBranch_F = '0; Stall_F = 0; Exc_F = 0; ExcPC_F = '0; ERet_F = 0;
        model_reset();
        #1;
        chk("rst_addr", imem_addr_F, 64'h0);
        chk("rst_elr",  ELR_F, 64'h0);
        chk("rst_flags", {62'b0, InExc_F, Misalign_F}, 64'h0);
        repeat (5) @(posedge clk);
        #1 chk("rst_hold_addr", imem_addr_F, 64'h0);
        #1 reset = 1'b0;

        // 1. sequential fetch, then async reset between edges
        repeat (4) idle();
        @(posedge clk); #2 now("seq_16", imem_addr_F, 64'd16);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk("async_rst_addr", imem_addr_F, 64'h0);
        chk("async_rst_inexc", {63'b0, InExc_F}, 64'h0);
        model_reset();
        @(posedge clk); #2 reset = 1'b0;
        idle();

        // 2. aligned branch, then misaligned trap
        branch(64'hFE0);
        branch(64'hFEA);
        @(posedge clk); #2;
        now("mis_addr", imem_addr_F, 64'hD8);
        now("mis_elr",  ELR_F, 64'hFEA);
        now("mis_flag", {63'b0, Misalign_F}, 64'h1);
        idle();
        @(posedge clk); #2 now("mis_pulse_end", {63'b0, Misalign_F}, 64'h0);
        step(0, '0, 0, 0, '0, 1);

        // 3. exception and return
        branch(64'h40);
        step(0, '0, 0, 1, 64'h3C, 0);
        idle(); idle();
        step(0, '0, 0, 0, '0, 1);
        @(posedge clk); #2 now("eret_addr", imem_addr_F, 64'h3C);

        // 4. nested exception, simultaneous Exc+ERET
        step(0, '0, 0, 1, 64'h3C, 0);
        step(0, '0, 0, 1, 64'h100, 0);
        @(posedge clk); #2 now("nested_elr", ELR_F, 64'h3C);
        step(0, '0, 0, 1, 64'h200, 1);
        @(posedge clk); #2 now("exc_eret_inexc", {63'b0, InExc_F}, 64'h1);
        step(0, '0, 0, 0, '0, 1);

        // 5. stall, stall overridden by branch, stray ERET
        branch(64'h20);
        repeat (3) step(0, '0, 1, 0, '0, 0);
        @(posedge clk); #2 now("stall_hold", imem_addr_F, 64'h20);
        step(1, 64'h80, 1, 0, '0, 0);
        step(0, '0, 0, 0, '0, 1);
        @(posedge clk); #2 now("stray_eret", imem_addr_F, 64'h84);

        // 6. wrap-around
        branch(64'hFFFF_FFFF_FFFF_FFFC);
        idle();
        @(posedge clk); #2 now("wrap_addr", imem_addr_F, 64'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] br;
            logic [63:0] epc;
            int sel;
            sel = int'($urandom_range(0, 7));
            br  = {48'h0, 16'($urandom) & 16'hFFFC};
            if (sel == 0) br = 64'hFFFF_FFFF_FFFF_FFFC;
            else if (sel < 3) br = br | 64'($urandom_range(1, 3));
            epc = {$urandom, $urandom};
            step($urandom_range(0, 5) == 0, br, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, epc, $urandom_range(0, 7) == 0);
        end

        repeat (3) @(posedge clk);
        #2 chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
